// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch read protocol (initiator and responder).
package fetch_pkg;

  // Default widths, shared with the fetch initiator side.
  localparam int FETCH_ADDR_BITS = 8;
  localparam int FETCH_DATA_BITS = 16;

  // Per-channel life cycle of one memory read.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAITING  = 2'b01,
    RELAYING = 2'b10
  } chan_state_t;

  // Width of an index into n items; never zero so a single consumer still gets a 1-bit index.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fetch_responder_rr_pick.sv
// Combinational round-robin selector: first requesting slot at or after the start pointer.
module rr_pick
  import fetch_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_bits(N)
) (
  input  logic [N-1:0]  request,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] index
);

  // Scan from the farthest offset down so the nearest requester after start wins.
  always_comb begin
    int pos;
    found = 1'b0;
    index = '0;
    pos   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = (int'(start) + k) % N;
      if (request[pos]) begin
        found = 1'b1;
        index = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/fetch_responder.sv
// Fetch responder: serves consumer read requests over a set of program-memory read channels.
module fetch_responder
  import fetch_pkg::*;
#(
  parameter int ADDR_BITS     = FETCH_ADDR_BITS,
  parameter int DATA_BITS     = FETCH_DATA_BITS,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data
);

  localparam int IW = idx_bits(NUM_CONSUMERS);
  localparam logic [NUM_CONSUMERS-1:0] ONE_HOT0 = NUM_CONSUMERS'(1);

  chan_state_t          state_reg   [NUM_CHANNELS];
  chan_state_t          state_next  [NUM_CHANNELS];
  logic [IW-1:0]        owner_reg   [NUM_CHANNELS];
  logic [IW-1:0]        owner_next  [NUM_CHANNELS];
  logic [IW-1:0]        rr_ptr_reg  [NUM_CHANNELS];
  logic [IW-1:0]        rr_ptr_next [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] addr_reg    [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] addr_next   [NUM_CHANNELS];
  logic [DATA_BITS-1:0] data_reg    [NUM_CHANNELS];
  logic [DATA_BITS-1:0] data_next   [NUM_CHANNELS];

  logic [NUM_CONSUMERS-1:0]   claimed;
  logic [NUM_CHANNELS-1:0]    pick_found;
  logic [NUM_CHANNELS*IW-1:0] pick_idx;

  // A consumer stays claimed from the claim edge until its owner returns to IDLE.
  always_comb begin
    claimed = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (state_reg[c] != IDLE) begin
        claimed[owner_reg[c]] = 1'b1;
      end
    end
  end

  // Claim chain: lower channels choose first and hide their pick from higher channels.
  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
      logic [NUM_CONSUMERS-1:0] excl_in;
      logic [NUM_CONSUMERS-1:0] excl_out;
      logic [NUM_CONSUMERS-1:0] mask;
      logic                     found;
      logic [IW-1:0]            pick;

      if (gi == 0) begin : g_head
        assign excl_in = '0;
      end else begin : g_tail
        assign excl_in = g_chan[gi-1].excl_out;
      end

      assign mask = consumer_read_valid & ~claimed & ~excl_in;

      rr_pick #(
        .N  (NUM_CONSUMERS),
        .IW (IW)
      ) u_pick (
        .request (mask),
        .start   (rr_ptr_reg[gi]),
        .found   (found),
        .index   (pick)
      );

      assign pick_found[gi]          = found && (state_reg[gi] == IDLE);
      assign pick_idx[gi*IW +: IW]   = pick;
      assign excl_out = excl_in | (pick_found[gi] ? (ONE_HOT0 << pick) : '0);
    end
  endgenerate

  // Channel state registers; reset aborts any read in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_reg[c]  <= IDLE;
        owner_reg[c]  <= '0;
        rr_ptr_reg[c] <= '0;
        addr_reg[c]   <= '0;
        data_reg[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_reg[c]  <= state_next[c];
        owner_reg[c]  <= owner_next[c];
        rr_ptr_reg[c] <= rr_ptr_next[c];
        addr_reg[c]   <= addr_next[c];
        data_reg[c]   <= data_next[c];
      end
    end
  end

  // Next-state logic per channel: claim, wait for memory, relay until the consumer lets go.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      state_next[c]  = state_reg[c];
      owner_next[c]  = owner_reg[c];
      rr_ptr_next[c] = rr_ptr_reg[c];
      addr_next[c]   = addr_reg[c];
      data_next[c]   = data_reg[c];
      case (state_reg[c])
        IDLE: begin
          if (pick_found[c]) begin
            state_next[c] = WAITING;
            owner_next[c] = pick_idx[c*IW +: IW];
            addr_next[c]  = consumer_read_address[int'(pick_idx[c*IW +: IW])*ADDR_BITS +: ADDR_BITS];
          end
        end
        WAITING: begin
          // Address is frozen here; later consumer address changes are ignored.
          if (mem_read_ready[c]) begin
            state_next[c]  = RELAYING;
            data_next[c]   = mem_read_data[c*DATA_BITS +: DATA_BITS];
            rr_ptr_next[c] = (owner_reg[c] == IW'(NUM_CONSUMERS - 1)) ? '0 : owner_reg[c] + 1'b1;
          end
        end
        RELAYING: begin
          // Hold the response until the owner's valid is seen low, so one request is served once.
          if (!consumer_read_valid[owner_reg[c]]) begin
            state_next[c] = IDLE;
            data_next[c]  = '0;
          end
        end
        default: begin
          state_next[c] = IDLE;
        end
      endcase
    end
  end

  // Route channel registers to memory-side and owning consumer outputs.
  always_comb begin
    mem_read_valid      = '0;
    mem_read_address    = '0;
    consumer_read_ready = '0;
    consumer_read_data  = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      mem_read_valid[c] = (state_reg[c] == WAITING);
      mem_read_address[c*ADDR_BITS +: ADDR_BITS] = addr_reg[c];
      if (state_reg[c] == RELAYING) begin
        consumer_read_ready[owner_reg[c]] = 1'b1;
        consumer_read_data[int'(owner_reg[c])*DATA_BITS +: DATA_BITS] = data_reg[c];
      end
    end
  end

endmodule

// File: tb/tb_fetch_responder.sv
// Bench for fetch_responder: a 1-channel and a 2-channel instance, a scripted memory and a per-cycle model.
module tb_fetch_responder;

  logic clk;
  logic reset_n;

  // Consumer side, index 0 = single-channel instance, index 1 = dual-channel instance.
  logic [3:0]  cvalid [2];
  logic [31:0] caddr  [2];
  logic [3:0]  cready [2];
  logic [63:0] cdata  [2];

  logic        m1_valid;
  logic [7:0]  m1_addr;
  logic        m1_ready;
  logic [15:0] m1_data;
  logic [1:0]  m2_valid;
  logic [15:0] m2_addr;
  logic [1:0]  m2_ready;
  logic [31:0] m2_data;

  // Memory channels flattened: 0 = inst0 ch0, 1 = inst1 ch0, 2 = inst1 ch1.
  logic        mv [3];
  logic [7:0]  ma [3];
  logic        mr [3];
  logic [15:0] md [3];
  int          dly [3];

  int total = 0;
  int bad   = 0;
  int rd_cnt [3];
  int order0 [$];
  int order1 [$];

  assign mv[0] = m1_valid;
  assign mv[1] = m2_valid[0];
  assign mv[2] = m2_valid[1];
  assign ma[0] = m1_addr;
  assign ma[1] = m2_addr[7:0];
  assign ma[2] = m2_addr[15:8];
  assign m1_ready = mr[0];
  assign m1_data  = md[0];
  assign m2_ready = {mr[2], mr[1]};
  assign m2_data  = {md[2], md[1]};

  fetch_responder #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) u_dut1 (
    .clk                   (clk),
    .reset_n               (reset_n),
    .consumer_read_valid   (cvalid[0]),
    .consumer_read_address (caddr[0]),
    .consumer_read_ready   (cready[0]),
    .consumer_read_data    (cdata[0]),
    .mem_read_valid        (m1_valid),
    .mem_read_address      (m1_addr),
    .mem_read_ready        (m1_ready),
    .mem_read_data         (m1_data)
  );

  fetch_responder #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) u_dut2 (
    .clk                   (clk),
    .reset_n               (reset_n),
    .consumer_read_valid   (cvalid[1]),
    .consumer_read_address (caddr[1]),
    .consumer_read_ready   (cready[1]),
    .consumer_read_data    (cdata[1]),
    .mem_read_valid        (m2_valid),
    .mem_read_address      (m2_addr),
    .mem_read_ready        (m2_ready),
    .mem_read_data         (m2_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Program memory contents as the bench defines them.
  function automatic logic [15:0] memfn(input logic [7:0] a);
    if (a == 8'h1A) return 16'hBEEF;
    return {~a, a};
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scripted memory: answers each request dly[k] cycles after it first sees it, one-cycle strobe.
  initial begin
    int cnt [3];
    for (int k = 0; k < 3; k++) begin
      mr[k] = 1'b0; md[k] = '0; cnt[k] = 0;
    end
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        if (!reset_n) begin
          mr[k] = 1'b0; md[k] = '0; cnt[k] = 0;
        end else if (mr[k]) begin
          mr[k] = 1'b0; md[k] = '0; cnt[k] = 0;
        end else if (mv[k]) begin
          if (cnt[k] >= dly[k]) begin
            mr[k] = 1'b1; md[k] = memfn(ma[k]);
          end else begin
            cnt[k]++;
          end
        end
      end
    end
  end

  // Per-cycle model: a response carries memory[address of the request], one service per request,
  // ready clears the cycle after valid is seen low, memory address stable while requested.
  initial begin
    bit         pv  [2][4];
    bit         pr  [2][4];
    bit         srv [2][4];
    logic [7:0] ra  [2][4];
    bit         pmv [3];
    logic [7:0] pma [3];
    logic [15:0] d;
    logic [15:0] e;
    for (int k = 0; k < 3; k++) rd_cnt[k] = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        for (int j = 0; j < 2; j++) begin
          check(cready[j] == 4'b0, "reset_ready", 32'(cready[j]), 0);
          check(cdata[j] == 64'b0, "reset_data", cdata[j][31:0], 0);
          for (int i = 0; i < 4; i++) begin
            pv[j][i] = 0; pr[j][i] = 0; srv[j][i] = 0;
          end
        end
        for (int k = 0; k < 3; k++) begin
          check(mv[k] == 1'b0, "reset_mem_valid", 32'(mv[k]), 0);
          pmv[k] = 0;
        end
      end else begin
        for (int j = 0; j < 2; j++) begin
          for (int i = 0; i < 4; i++) begin
            if (cvalid[j][i] && !pv[j][i]) begin
              ra[j][i]  = caddr[j][i*8 +: 8];
              srv[j][i] = 0;
            end
            d = cdata[j][i*16 +: 16];
            e = cready[j][i] ? memfn(ra[j][i]) : 16'h0;
            check(d == e, "resp_data", 32'(d), 32'(e));
            if (cready[j][i] && !pr[j][i]) begin
              check(!srv[j][i], "single_service", 32'(i), 32'(j));
              srv[j][i] = 1;
              if (j == 0) order0.push_back(i); else order1.push_back(i);
            end
            if (pr[j][i] && !pv[j][i]) check(cready[j][i] == 1'b0, "ready_release", 32'(cready[j][i]), 0);
            pv[j][i] = cvalid[j][i];
            pr[j][i] = cready[j][i];
          end
        end
        for (int k = 0; k < 3; k++) begin
          if (mv[k] && !pmv[k]) rd_cnt[k]++;
          if (mv[k] && pmv[k]) check(ma[k] == pma[k], "mem_addr_stable", 32'(ma[k]), 32'(pma[k]));
          pmv[k] = mv[k];
          pma[k] = ma[k];
        end
      end
    end
  end

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    reset_n   = 1'b0;
    cvalid[0] = '0; cvalid[1] = '0;
    caddr[0]  = '0; caddr[1]  = '0;
    @(posedge clk);
    @(posedge clk);
    release_reset();
  endtask

  // Wait for ready of consumer i on instance j; lat counts edges since the call.
  task automatic wait_ready(input int j, input int i, input int budget, output int lat);
    lat = 0;
    while (!cready[j][i] && lat < budget) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int base;
    int b1;
    int b2;
    int cyc;
    int got;
    int nr [4];
    logic [7:0] seen;
    int exp_rr [5];
    exp_rr = '{0, 1, 2, 3, 0};

    reset_n = 1'b0;
    cvalid[0] = '0; cvalid[1] = '0;
    caddr[0]  = '0; caddr[1]  = '0;
    for (int k = 0; k < 3; k++) dly[k] = 0;
    repeat (3) @(posedge clk);
    release_reset();

    // Single request: consumer 2, address 0x1A, memory answers after 3 cycles.
    dly[0] = 3;
    base = rd_cnt[0];
    caddr[0][16 +: 8] = 8'h1A;
    cvalid[0][2] = 1'b1;
    lat = 0; seen = '0;
    while (!cready[0][2] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (mv[0]) seen = ma[0];
    end
    check(cready[0][2] == 1'b1, "t1_ready", 32'(cready[0][2]), 1);
    check(lat == 5, "t1_latency", 32'(lat), 5);
    check(seen == 8'h1A, "t1_mem_addr", 32'(seen), 32'h1A);
    check(cdata[0][32 +: 16] == 16'hBEEF, "t1_data", 32'(cdata[0][32 +: 16]), 32'hBEEF);
    $display("tb: single c2 addr=1a data=%h latency=%0d", cdata[0][32 +: 16], lat);
    @(posedge clk); #1;
    check(cready[0][2] == 1'b1, "t1_ready_held", 32'(cready[0][2]), 1);
    cvalid[0][2] = 1'b0;
    @(posedge clk); #1;
    check(cready[0][2] == 1'b0, "t1_ready_drop", 32'(cready[0][2]), 0);
    repeat (4) @(posedge clk); #1;
    check(rd_cnt[0] - base == 1, "t1_reads", 32'(rd_cnt[0] - base), 1);

    // Round robin on one channel, all consumers re-requesting after each response.
    apply_reset();
    dly[0] = 1;
    base = order0.size();
    for (int i = 0; i < 4; i++) begin
      nr[i] = 0;
      caddr[0][i*8 +: 8] = 8'(8'h40 + i);
      cvalid[0][i] = 1'b1;
    end
    cyc = 0;
    while (order0.size() - base < 5 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      for (int i = 0; i < 4; i++) begin
        if (cvalid[0][i] && cready[0][i]) begin
          cvalid[0][i] = 1'b0;
        end else if (!cvalid[0][i] && !cready[0][i]) begin
          nr[i]++;
          caddr[0][i*8 +: 8] = 8'(8'h40 + 16 * nr[i] + i);
          cvalid[0][i] = 1'b1;
        end
      end
    end
    cvalid[0] = '0;
    for (int n = 0; n < 5; n++) begin
      got = (base + n < order0.size()) ? order0[base + n] : -1;
      check(got == exp_rr[n], "rr_order", 32'(got), 32'(exp_rr[n]));
      $display("tb: rr service %0d -> consumer %0d", n, got);
    end
    repeat (4) @(posedge clk); #1;

    // Two channels: consumers 0 and 3 together; channel 1 memory answers first.
    apply_reset();
    dly[1] = 4; dly[2] = 1;
    base = order1.size(); b1 = rd_cnt[1]; b2 = rd_cnt[2];
    caddr[1][0 +: 8]  = 8'h10;
    caddr[1][24 +: 8] = 8'h33;
    cvalid[1] = 4'b1001;
    @(posedge clk); #1;
    check(mv[1] == 1'b1 && mv[2] == 1'b1, "t3_both_claim", {30'b0, mv[2], mv[1]}, 3);
    check(ma[1] == 8'h10, "t3_ch0_addr", 32'(ma[1]), 32'h10);
    check(ma[2] == 8'h33, "t3_ch1_addr", 32'(ma[2]), 32'h33);
    cyc = 0;
    while (cvalid[1] != 4'b0 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      for (int i = 0; i < 4; i++) begin
        if (cvalid[1][i] && cready[1][i]) cvalid[1][i] = 1'b0;
      end
    end
    check(cvalid[1] == 4'b0, "t3_both_served", 32'(cvalid[1]), 0);
    repeat (3) @(posedge clk); #1;
    got = (base < order1.size()) ? order1[base] : -1;
    check(got == 3, "t3_first_done", 32'(got), 3);
    got = (base + 1 < order1.size()) ? order1[base + 1] : -1;
    check(got == 0, "t3_second_done", 32'(got), 0);
    check(rd_cnt[1] - b1 == 1 && rd_cnt[2] - b2 == 1, "t3_reads", 32'(rd_cnt[1] - b1 + rd_cnt[2] - b2), 2);
    $display("tb: dual channel c0/c3 completion order %0d then %0d", order1[base], got);

    // Held valid: zero-wait memory, consumer 1 keeps valid 5 cycles past ready.
    apply_reset();
    dly[0] = 0;
    base = rd_cnt[0];
    caddr[0][8 +: 8] = 8'h5C;
    cvalid[0][1] = 1'b1;
    wait_ready(0, 1, 20, lat);
    check(lat == 2, "held_latency", 32'(lat), 2);
    check(cdata[0][16 +: 16] == 16'hA35C, "held_data", 32'(cdata[0][16 +: 16]), 32'hA35C);
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      check(cready[0][1] == 1'b1, "held_ready", 32'(cready[0][1]), 1);
    end
    cvalid[0][1] = 1'b0;
    @(posedge clk); #1;
    check(cready[0][1] == 1'b0, "held_drop", 32'(cready[0][1]), 0);
    repeat (3) @(posedge clk); #1;
    check(rd_cnt[0] - base == 1, "held_reads", 32'(rd_cnt[0] - base), 1);
    $display("tb: held valid c1 latency=%0d reads=%0d", lat, rd_cnt[0] - base);

    // Asynchronous reset while a read is outstanding, then a normal read.
    apply_reset();
    dly[1] = 10;
    caddr[1][16 +: 8] = 8'h77;
    cvalid[1][2] = 1'b1;
    cyc = 0;
    while (!mv[1] && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(mv[1] == 1'b1, "ar_waiting", 32'(mv[1]), 1);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    check(mv[1] == 1'b0 && mv[2] == 1'b0, "ar_mem_valid", {30'b0, mv[2], mv[1]}, 0);
    check(cready[1] == 4'b0, "ar_ready", 32'(cready[1]), 0);
    check(cdata[1] == 64'b0, "ar_data", cdata[1][31:0], 0);
    cvalid[1] = '0;
    @(posedge clk);
    @(posedge clk);
    release_reset();
    dly[1] = 0;
    caddr[1][16 +: 8] = 8'h78;
    cvalid[1][2] = 1'b1;
    wait_ready(1, 2, 20, lat);
    check(cready[1][2] == 1'b1, "ar_after_ready", 32'(cready[1][2]), 1);
    check(cdata[1][32 +: 16] == 16'h8778, "ar_after_data", 32'(cdata[1][32 +: 16]), 32'h8778);
    $display("tb: after reset c2 addr=78 data=%h latency=%0d", cdata[1][32 +: 16], lat);
    cvalid[1][2] = 1'b0;
    repeat (3) @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
